// File: rtl/sfi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfi_pkg : opcode typedef, sandboxed-opcode table and defaults      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sfi_pkg;

  localparam int c_opc_w     = 6;
  localparam int c_n_sandbox = 10;

  typedef logic [c_opc_w-1:0] opc_t;

  localparam opc_t c_sandbox_opc [c_n_sandbox] = '{
    6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd56, 6'd60, 6'd63
  };

  localparam logic [63:0] c_keep_mask_default  = 64'h00FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_reset_base_default = 64'hA2FF_FFFF_FFFF_FFFF;

  function automatic logic is_sandboxed(input opc_t opc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < c_n_sandbox; i++) begin
      if (opc == c_sandbox_opc[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfi_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfi_pipe_stage : generic valid/ready register slice                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sfi_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load when empty or when the current contents leave this cycle.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/sfi_rewrite_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfi_rewrite_pipe : 2-stage SFI instruction sandboxing rewriter     |
// | Optional trap check enabled by defining SFI_TRAP_EN.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sfi_rewrite_pipe
  import sfi_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter int                OPC_LSB    = 26,
  parameter int                OPC_W      = 6,
  parameter int                N_REGIONS  = 4,
  parameter logic [DATA_W-1:0] KEEP_MASK  = c_keep_mask_default,
  parameter logic [DATA_W-1:0] RESET_BASE = c_reset_base_default,
  parameter int                CNT_W      = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [DATA_W-1:0]                                   in_data,
  input  logic [((N_REGIONS > 1) ? $clog2(N_REGIONS) : 1)-1:0] in_sel,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [DATA_W-1:0]                                   out_data,
  output logic                                                out_rewritten,
  input  logic                                                cfg_we,
  input  logic [((N_REGIONS > 1) ? $clog2(N_REGIONS) : 1)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]                                   cfg_base,
  output logic [CNT_W-1:0]                                    rewrite_cnt,
  output logic                                                trap,
  output logic [CNT_W-1:0]                                    trap_cnt
);

  localparam int c_sel_w = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int c_s1_w  = 2 * DATA_W + 1;

  logic [DATA_W-1:0]  r_base [N_REGIONS];
  logic [CNT_W-1:0]   r_rewrite_cnt;
  logic [c_sel_w-1:0] w_sel;
  logic               w_is_mem;
  logic [c_s1_w-1:0]  w_s1_in;
  logic [c_s1_w-1:0]  w_s1_out;
  logic               w_s1_valid;
  logic               w_s2_load;
  logic               w_s1_mem;
  logic [DATA_W-1:0]  w_s1_base;
  logic [DATA_W-1:0]  w_s1_data;
  logic [DATA_W-1:0]  w_result;
  logic               w_hs;

  // Out-of-range selects fall back to region 0.
  assign w_sel    = ({{(32-c_sel_w){1'b0}}, in_sel} < 32'(N_REGIONS)) ? in_sel : '0;
  assign w_is_mem = is_sandboxed(opc_t'(in_data[OPC_LSB +: OPC_W]));
  assign w_s1_in  = {w_is_mem, r_base[w_sel], in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGIONS; i++) r_base[i] <= RESET_BASE;
    end else if (cfg_we) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (cfg_idx == c_sel_w'(i)) r_base[i] <= cfg_base;
      end
    end
  end

  sfi_pipe_stage #(.WIDTH(c_s1_w)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_load),
    .o_data  (w_s1_out)
  );

  assign {w_s1_mem, w_s1_base, w_s1_data} = w_s1_out;
  assign w_result = w_s1_mem ? ((w_s1_data & KEEP_MASK) | w_s1_base) : w_s1_data;
  assign w_hs     = out_valid && out_ready;

`ifdef SFI_TRAP_EN
  localparam int c_s2_w = DATA_W + 2;
  logic [c_s2_w-1:0] w_s2_in;
  logic [c_s2_w-1:0] w_s2_out;
  logic              w_trap_hit;
  logic              w_s2_trap;
  logic [CNT_W-1:0]  r_trap_cnt;

  // A sandboxed word whose upper bits disagree with its region is replaced by a NOP.
  assign w_trap_hit = w_s1_mem && ((w_s1_data & ~KEEP_MASK) != (w_s1_base & ~KEEP_MASK));
  assign w_s2_in    = {w_trap_hit, w_s1_mem && !w_trap_hit, w_trap_hit ? '0 : w_result};
  assign {w_s2_trap, out_rewritten, out_data} = w_s2_out;
  assign trap       = w_hs && w_s2_trap;

  always_ff @(posedge clk) begin
    if (rst) r_trap_cnt <= '0;
    else if (trap && r_trap_cnt != '1) r_trap_cnt <= r_trap_cnt + 1'b1;
  end

  assign trap_cnt = r_trap_cnt;
`else
  localparam int c_s2_w = DATA_W + 1;
  logic [c_s2_w-1:0] w_s2_in;
  logic [c_s2_w-1:0] w_s2_out;

  assign w_s2_in  = {w_s1_mem, w_result};
  assign {out_rewritten, out_data} = w_s2_out;
  assign trap     = 1'b0;
  assign trap_cnt = '0;
`endif

  sfi_pipe_stage #(.WIDTH(c_s2_w)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_load),
    .i_data  (w_s2_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_rewrite_cnt <= '0;
    else if (w_hs && out_rewritten && r_rewrite_cnt != '1) r_rewrite_cnt <= r_rewrite_cnt + 1'b1;
  end

  assign rewrite_cnt = r_rewrite_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sfi_rewrite_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sfi_rewrite_pipe : randomized bench with a behavioural model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sfi_rewrite_pipe;

  localparam int          NR    = 3;
  localparam logic [63:0] KEEP  = 64'h00FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RBASE = 64'hA2FF_FFFF_FFFF_FFFF;
`ifdef SFI_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_rewritten;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [63:0] cfg_base = '0;
  logic [15:0] rewrite_cnt, trap_cnt;
  logic        trap;

  sfi_rewrite_pipe #(.N_REGIONS(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rewritten(out_rewritten), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .rewrite_cnt(rewrite_cnt), .trap(trap), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] d; logic rw; logic tr; } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic        e_ok;
  logic [63:0] m_base [NR];
  logic [15:0] m_rw = '0, m_tr = '0, m_rw_pre, m_tr_pre;
  int          sb_list [10] = '{40, 41, 42, 43, 44, 45, 46, 56, 60, 63};
  int          n_chk = 0, n_err = 0;
  logic        o_acc, o_rdy, o_vld, o_hs, o_rw, o_trap;
  logic [63:0] o_data;
  logic [15:0] o_cnt, o_tcnt;

  // Expected result straight from the rewrite rules.
  function automatic exp_t model(input logic [63:0] d, input logic [1:0] sel);
    exp_t        r;
    int          opc;
    logic [63:0] b;
    opc  = int'(d[31:26]);
    b    = (int'(sel) < NR) ? m_base[sel] : m_base[0];
    r.tr = 1'b0;
    if (!(opc inside {40, 41, 42, 43, 44, 45, 46, 56, 60, 63})) begin
      r.d = d; r.rw = 1'b0;
    end else if (TRAP_EN && (((d ^ b) & ~KEEP) != 64'd0)) begin
      r.d = 64'd0; r.rw = 1'b0; r.tr = 1'b1;
    end else begin
      r.d = (d & KEEP) | b; r.rw = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] gen_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if ($urandom_range(0, 2) != 0) w[31:26] = 6'(sb_list[$urandom_range(0, 9)]);
    if ($urandom_range(0, 1) != 0) w[63:56] = 8'hA2;
    return w;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, update the model.
  task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [1:0] sel,
                             input logic ordy, input logic we, input logic [1:0] idx,
                             input logic [63:0] base);
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = sel; out_ready = ordy;
    cfg_we = we; cfg_idx = idx; cfg_base = base;
    #1;
    o_acc = in_valid && in_ready; o_rdy = in_ready; o_vld = out_valid;
    o_hs = out_valid && out_ready; o_data = out_data; o_rw = out_rewritten;
    o_trap = trap; o_cnt = rewrite_cnt; o_tcnt = trap_cnt;
    m_rw_pre = m_rw; m_tr_pre = m_tr; e_ok = 1'b0;
    if (o_hs && exp_q.size() > 0) begin
      e = exp_q.pop_front(); e_ok = 1'b1;
      if (e.rw && m_rw != 16'hFFFF) m_rw++;
      if (e.tr && m_tr != 16'hFFFF) m_tr++;
    end
    if (o_acc) exp_q.push_back(model(d, sel));
    if (we && int'(idx) < NR) m_base[idx] = base;
  endtask

  task automatic wait_out(input int budget);
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    for (int i = 1; i < budget && !o_hs; i++) drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    exp_q.delete(); m_rw = '0; m_tr = '0;
    for (int i = 0; i < NR; i++) m_base[i] = RBASE;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_chk++; if (out_rewritten !== 1'b0) begin n_err++; $display("FAIL reset out_rewritten: got %b want 0", out_rewritten); end
    n_chk++; if (rewrite_cnt !== 16'd0) begin n_err++; $display("FAIL reset rewrite_cnt: got %0d want 0", rewrite_cnt); end
    n_chk++; if (trap !== 1'b0 || trap_cnt !== 16'd0) begin n_err++; $display("FAIL reset trap: got %b/%0d want 0/0", trap, trap_cnt); end
    rst = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rewrite();
    drive_cycle(1'b1, 64'h1234_5678_AC00_0010, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_acc !== 1'b1) begin n_err++; $display("FAIL rewrite accept: got %b want 1", o_acc); end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL rewrite early valid: got %b want 0", o_vld); end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_vld !== 1'b1 || e_ok !== 1'b1) begin n_err++; $display("FAIL rewrite latency: got valid %b want 1", o_vld); end
    n_chk++; if (o_data !== e.d || o_rw !== e.rw || o_trap !== e.tr) begin
      n_err++; $display("FAIL rewrite data: got %h/%b/%b want %h/%b/%b", o_data, o_rw, o_trap, e.d, e.rw, e.tr); end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_cnt !== m_rw_pre) begin n_err++; $display("FAIL rewrite_cnt: got %0d want %0d", o_cnt, m_rw_pre); end
  endtask

  task automatic test_passthrough();
    drive_cycle(1'b1, 64'h0000_0000_0000_0020, 2'd2, 1'b1, 1'b0, 2'd0, 64'd0);
    wait_out(6);
    n_chk++; if (o_hs !== 1'b1 || e_ok !== 1'b1) begin n_err++; $display("FAIL passthrough timeout: got hs %b want 1", o_hs); end
    n_chk++; if (o_data !== 64'h20 || o_rw !== 1'b0) begin
      n_err++; $display("FAIL passthrough data: got %h/%b want %h/0", o_data, o_rw, 64'h20); end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_cnt !== m_rw_pre) begin n_err++; $display("FAIL passthrough cnt: got %0d want %0d", o_cnt, m_rw_pre); end
  endtask

  task automatic test_cfg_race();
    drive_cycle(1'b1, 64'hFF00_0000_A000_0004, 2'd1, 1'b1, 1'b1, 2'd1, 64'h5500_0000_0000_0000);
    drive_cycle(1'b1, 64'hFF00_0000_A000_0004, 2'd1, 1'b1, 1'b0, 2'd0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      wait_out(6);
      n_chk++; if (o_hs !== 1'b1 || e_ok !== 1'b1 || o_data !== e.d || o_rw !== e.rw) begin
        n_err++; $display("FAIL cfg_race word%0d: got %h/%b want %h/%b", k, o_data, o_rw, e.d, e.rw); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w [8];
    logic [63:0] cur;
    int sent = 0, got = 0;
    for (int i = 0; i < 8; i++) w[i] = gen_word();
    for (int t = 0; t < 60 && got < 8; t++) begin
      cur = (sent < 8) ? w[sent] : 64'd0;
      drive_cycle(sent < 8, cur, 2'($urandom_range(0, 3)), t >= 5, 1'b0, 2'd0, 64'd0);
      if (o_acc) sent++;
      if (t == 4) begin
        n_chk++; if (sent != 2 || o_rdy !== 1'b0) begin n_err++; $display("FAIL bp stall: got %0d accepted ready %b want 2/0", sent, o_rdy); end
      end
      if (o_vld && !o_hs) begin
        n_chk++; if (exp_q.size() == 0 || o_data !== exp_q[0].d) begin n_err++; $display("FAIL bp hold: got %h", o_data); end
      end
      if (o_hs) begin
        got++;
        n_chk++; if (e_ok !== 1'b1 || o_data !== e.d || o_rw !== e.rw) begin
          n_err++; $display("FAIL bp order: got %h/%b want %h/%b", o_data, o_rw, e.d, e.rw); end
      end
    end
    n_chk++; if (got != 8 || exp_q.size() != 0) begin n_err++; $display("FAIL bp count: got %0d want 8", got); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, gen_word(), 2'd0, 1'b0, 1'b0, 2'd0, 64'd0);
    drive_cycle(1'b1, gen_word(), 2'd1, 1'b0, 1'b0, 2'd0, 64'd0);
    do_reset();
    n_chk++; if (out_valid !== 1'b0 || rewrite_cnt !== 16'd0 || trap_cnt !== 16'd0) begin
      n_err++; $display("FAIL midreset state: got v%b cnt %0d tcnt %0d want 0/0/0", out_valid, rewrite_cnt, trap_cnt); end
    rst = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
      n_chk++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL midreset ghost: got valid %b want 0", o_vld); end
    end
  endtask

  task automatic test_trap();
    drive_cycle(1'b1, 64'h1200_0000_AC00_0010, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    drive_cycle(1'b1, 64'hA200_0000_AC00_0010, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      wait_out(6);
      n_chk++; if (o_hs !== 1'b1 || e_ok !== 1'b1 || o_data !== e.d || o_rw !== e.rw || o_trap !== e.tr) begin
        n_err++; $display("FAIL trap word%0d: got %h/%b/%b want %h/%b/%b", k, o_data, o_rw, o_trap, e.d, e.rw, e.tr); end
    end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (o_tcnt !== m_tr_pre || o_trap !== 1'b0) begin
      n_err++; $display("FAIL trap_cnt: got %0d/%b want %0d/0", o_tcnt, o_trap, m_tr_pre); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      drive_cycle(1'($urandom_range(0, 1)), gen_word(), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)), {$urandom, $urandom});
      if (o_hs) begin
        n_chk++; if (e_ok !== 1'b1 || o_data !== e.d || o_rw !== e.rw || o_trap !== e.tr) begin
          n_err++; $display("FAIL random t%0d: got %h/%b/%b want %h/%b/%b", t, o_data, o_rw, o_trap, e.d, e.rw, e.tr); end
      end else if (o_trap !== 1'b0) begin
        n_chk++; n_err++; $display("FAIL random trap idle t%0d: got %b want 0", t, o_trap);
      end
    end
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
      if (o_hs) begin
        n_chk++; if (e_ok !== 1'b1 || o_data !== e.d || o_rw !== e.rw) begin
          n_err++; $display("FAIL drain: got %h/%b want %h/%b", o_data, o_rw, e.d, e.rw); end
      end
    end
    drive_cycle(1'b0, 64'd0, 2'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    n_chk++; if (exp_q.size() != 0 || o_vld !== 1'b0) begin n_err++; $display("FAIL random leftover: got %0d pending", exp_q.size()); end
    n_chk++; if (o_cnt !== m_rw_pre || o_tcnt !== m_tr_pre) begin
      n_err++; $display("FAIL random counters: got %0d/%0d want %0d/%0d", o_cnt, o_tcnt, m_rw_pre, m_tr_pre); end
  endtask

  initial begin
    test_reset();
    test_rewrite();
    test_passthrough();
    test_cfg_race();
    test_backpressure();
    test_reset_mid();
    test_trap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
